cbg_resp: RTL and testbench

CBG_RESP -- requirements
Module: cbg_resp

---
 rtl/param_define.sv | 28 ++
 rtl/cbg_resp_rr_arb.sv | 31 +++
 rtl/cbg_resp.sv | 109 ++++++++++
 tb/tb_cbg_resp.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/param_define.sv
// rtl/param_define.sv - shared widths, response-bus layout and FSM encoding for cbg_resp
package param_define;

    localparam int NQ      = 4;
    localparam int ADDR_W  = 16;
    localparam int DATA_W  = 32;
    localparam int DEPTH   = 256;
    localparam int AW      = $clog2(DEPTH);
    localparam int SW      = $clog2(NQ);

    // Bus widths seen by the LSU side
    localparam int C_L_bus = DATA_W + SW + 2;
    localparam int R_Q     = NQ;
    localparam int W_Q     = NQ;
    localparam int A_bus   = NQ * ADDR_W;

    // Response bus layout: {rsp_valid, rsp_err, rsp_slot, rsp_data}
    localparam int RSP_DATA_LSB  = 0;
    localparam int RSP_SLOT_LSB  = DATA_W;
    localparam int RSP_ERR_BIT   = DATA_W + SW;
    localparam int RSP_VALID_BIT = DATA_W + SW + 1;

    typedef enum logic {
        CLEAR = 1'b0,
        SERVE = 1'b1
    } cbg_state_t;

endpackage

// File: rtl/cbg_resp_rr_arb.sv
// rtl/cbg_resp_rr_arb.sv - round-robin arbiter searching from rr_ptr+1
module rr_arb #(
    parameter int NQ = 4,
    parameter int SW = 2
) (
    input  logic [NQ-1:0] pending,
    input  logic [SW-1:0] rr_ptr,
    output logic [NQ-1:0] grant,
    output logic [SW-1:0] grant_idx
);

    int   idx;
    logic found;

    // First pending slot after rr_ptr wins; the last slot checked is rr_ptr itself
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int k = 1; k <= NQ; k++) begin
            idx = (int'(rr_ptr) + k) % NQ;
            if (!found && pending[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx[SW-1:0];
            end
        end
    end

endmodule

// File: rtl/cbg_resp.sv
// rtl/cbg_resp.sv - multi-slot LSU request arbiter over a cleared backing store
module cbg_resp #(
    parameter int NQ     = param_define::NQ,
    parameter int ADDR_W = param_define::ADDR_W,
    parameter int DATA_W = param_define::DATA_W,
    parameter int DEPTH  = param_define::DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NQ-1:0]            R_request,
    input  logic [NQ-1:0]            W_request,
    input  logic [NQ*ADDR_W-1:0]     LSU_addr_bus,
    input  logic [NQ*DATA_W-1:0]     wr_data_bus,
    output logic [NQ-1:0]            req_ack,
    output logic [DATA_W+$clog2(NQ)+1:0] CBG_to_LSU_bus,
    output logic                     busy
);
    import param_define::*;

    localparam int AW_L = $clog2(DEPTH);
    localparam int SW_L = $clog2(NQ);

    cbg_state_t          state;
    logic [AW_L-1:0]     clr_cnt;
    logic [SW_L-1:0]     rr_ptr;
    logic                busy_r;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic                rsp_valid;
    logic                rsp_err;
    logic [SW_L-1:0]     rsp_slot;
    logic [DATA_W-1:0]   rsp_data;

    logic [NQ-1:0]       pending;
    logic [NQ-1:0]       grant;
    logic [SW_L-1:0]     grant_idx;
    logic                serve_ok;
    logic                gv;
    logic [ADDR_W-1:0]   g_addr;
    logic [DATA_W-1:0]   g_wdata;
    logic                g_wr;
    logic                g_oor;
    logic [AW_L-1:0]     g_loc;

    assign pending  = R_request | W_request;

    rr_arb #(.NQ(NQ), .SW(SW_L)) u_arb (
        .pending   (pending),
        .rr_ptr    (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Grants only exist in SERVE outside reset; the write side wins when both are raised
    assign serve_ok = rst && (state == SERVE);
    assign req_ack  = serve_ok ? grant : '0;
    assign gv       = serve_ok && (|grant);
    assign g_addr   = LSU_addr_bus[grant_idx*ADDR_W +: ADDR_W];
    assign g_wdata  = wr_data_bus[grant_idx*DATA_W +: DATA_W];
    assign g_wr     = W_request[grant_idx];
    assign g_oor    = |g_addr[ADDR_W-1:AW_L];
    assign g_loc    = g_addr[AW_L-1:0];

    assign CBG_to_LSU_bus = {rsp_valid, rsp_err, rsp_slot, rsp_data};
    assign busy           = busy_r;

    // Control FSM: clear sweep, then arbitration pointer and registered response
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= CLEAR;
            clr_cnt   <= '0;
            busy_r    <= 1'b1;
            rr_ptr    <= SW_L'(NQ - 1);
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_slot  <= '0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= gv;
            if (gv) begin
                rr_ptr   <= grant_idx;
                rsp_err  <= g_oor;
                rsp_slot <= grant_idx;
                rsp_data <= (g_wr || g_oor) ? '0 : mem[g_loc];
            end
            case (state)
                CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == AW_L'(DEPTH - 1)) begin
                        state  <= SERVE;
                        busy_r <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Single write port: the clear sweep or an in-range granted write
    always_ff @(posedge clk) begin
        if (rst) begin
            if (state == CLEAR)
                mem[clr_cnt] <= '0;
            else if (gv && g_wr && !g_oor)
                mem[g_loc] <= g_wdata;
        end
    end

endmodule

// File: tb/tb_cbg_resp.sv
// tb/tb_cbg_resp.sv - directed table-driven bench for cbg_resp
module tb_cbg_resp;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    R_request;
    logic [3:0]    W_request;
    logic [63:0]   LSU_addr_bus;
    logic [127:0]  wr_data_bus;
    logic [3:0]    req_ack;
    logic [35:0]   CBG_to_LSU_bus;
    logic          busy;

    int checks = 0;
    int errors = 0;

    cbg_resp dut (
        .clk            (clk),
        .rst            (rst),
        .R_request      (R_request),
        .W_request      (W_request),
        .LSU_addr_bus   (LSU_addr_bus),
        .wr_data_bus    (wr_data_bus),
        .req_ack        (req_ack),
        .CBG_to_LSU_bus (CBG_to_LSU_bus),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   r;
        logic [3:0]   w;
        logic [63:0]  a;
        logic [127:0] d;
        logic [3:0]   ack;
        logic [35:0]  bus;
    } vec_t;

    vec_t vecs [19];

    function automatic logic [63:0] at(int s, logic [15:0] addr);
        logic [63:0] t;
        t = '0;
        t[s*16 +: 16] = addr;
        return t;
    endfunction

    function automatic logic [127:0] dat(int s, logic [31:0] d);
        logic [127:0] t;
        t = '0;
        t[s*32 +: 32] = d;
        return t;
    endfunction

    function automatic logic [35:0] rb(logic v, logic e, logic [1:0] s, logic [31:0] d);
        return {v, e, s, d};
    endfunction

    function automatic vec_t mkv(logic [3:0] r, logic [3:0] w, logic [63:0] a,
                                 logic [127:0] d, logic [3:0] ack, logic [35:0] bus);
        vec_t v;
        v.r = r; v.w = w; v.a = a; v.d = d; v.ack = ack; v.bus = bus;
        return v;
    endfunction

    task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic count_busy(output int n, output bit ack_seen, output bit bus_nz);
        n = 0; ack_seen = 1'b0; bus_nz = 1'b0;
        while (busy === 1'b1 && n < 400) begin
            if (req_ack !== 4'b0) ack_seen = 1'b1;
            if (CBG_to_LSU_bus !== 36'b0) bus_nz = 1'b1;
            n++;
            @(negedge clk);
        end
    endtask

    localparam logic [31:0] DB  = 32'hDEADBEEF;
    localparam logic [31:0] P12 = 32'h12345678;

    int n;
    bit ack_seen;
    bit bus_nz;
    logic [63:0] a10;

    initial begin
        a10 = {4{16'h0010}};
        vecs[0]  = mkv(4'b0100, 4'b0000, at(2, 16'h00FF), '0, 4'b0100, 36'b0);
        vecs[1]  = mkv(4'b0000, 4'b0010, at(1, 16'h0010), dat(1, DB), 4'b0010, rb(1, 0, 2, 0));
        vecs[2]  = mkv(4'b1000, 4'b0000, at(3, 16'h0010), '0, 4'b1000, rb(1, 0, 1, 0));
        vecs[3]  = mkv(4'b1111, 4'b0000, a10, '0, 4'b0001, rb(1, 0, 3, DB));
        vecs[4]  = mkv(4'b1110, 4'b0000, a10, '0, 4'b0010, rb(1, 0, 0, DB));
        vecs[5]  = mkv(4'b1100, 4'b0000, a10, '0, 4'b0100, rb(1, 0, 1, DB));
        vecs[6]  = mkv(4'b1000, 4'b0000, a10, '0, 4'b1000, rb(1, 0, 2, DB));
        vecs[7]  = mkv(4'b1111, 4'b0000, a10, '0, 4'b0001, rb(1, 0, 3, DB));
        vecs[8]  = mkv(4'b1110, 4'b0000, a10, '0, 4'b0010, rb(1, 0, 0, DB));
        vecs[9]  = mkv(4'b1100, 4'b0000, a10, '0, 4'b0100, rb(1, 0, 1, DB));
        vecs[10] = mkv(4'b1000, 4'b0000, a10, '0, 4'b1000, rb(1, 0, 2, DB));
        vecs[11] = mkv(4'b0001, 4'b0001, at(0, 16'h0005), dat(0, P12), 4'b0001, rb(1, 0, 3, DB));
        vecs[12] = mkv(4'b0001, 4'b0000, at(0, 16'h0005), '0, 4'b0001, rb(1, 0, 0, 0));
        vecs[13] = mkv(4'b0010, 4'b0000, at(1, 16'h0100), '0, 4'b0010, rb(1, 0, 0, P12));
        vecs[14] = mkv(4'b0000, 4'b0000, '0, '0, 4'b0000, rb(1, 1, 1, 0));
        vecs[15] = mkv(4'b0000, 4'b0000, '0, '0, 4'b0000, rb(0, 1, 1, 0));
        vecs[16] = mkv(4'b0000, 4'b0010, at(1, 16'h0105), dat(1, 32'hAAAA5555), 4'b0010, rb(0, 1, 1, 0));
        vecs[17] = mkv(4'b0100, 4'b0000, at(2, 16'h0005), '0, 4'b0100, rb(1, 1, 1, 0));
        vecs[18] = mkv(4'b0000, 4'b0000, '0, '0, 4'b0000, rb(1, 0, 2, P12));

        rst = 1'b0;
        R_request = '0; W_request = '0; LSU_addr_bus = '0; wr_data_bus = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("reset_bus", CBG_to_LSU_bus, 36'b0);
        count_busy(n, ack_seen, bus_nz);
        chk("init_busy_cycles", n, 256);
        chk("init_ack_during_clear", ack_seen, 0);
        chk("init_bus_during_clear", bus_nz, 0);

        for (int i = 0; i < 19; i++) begin
            @(posedge clk);
            #1;
            R_request    = vecs[i].r;
            W_request    = vecs[i].w;
            LSU_addr_bus = vecs[i].a;
            wr_data_bus  = vecs[i].d;
            @(negedge clk);
            chk($sformatf("v%0d_ack", i), req_ack, vecs[i].ack);
            chk($sformatf("v%0d_bus", i), CBG_to_LSU_bus, vecs[i].bus);
        end

        // Read grant, then reset in the following cycle while its response is out
        @(posedge clk);
        #1;
        R_request = 4'b0001; W_request = '0; LSU_addr_bus = at(0, 16'h0010);
        @(negedge clk);
        chk("mid_grant_ack", req_ack, 4'b0001);
        @(posedge clk);
        #1;
        rst = 1'b0; R_request = '0;
        @(negedge clk);
        chk("mid_ack_in_reset", req_ack, 4'b0);
        chk("mid_inflight_rsp", CBG_to_LSU_bus, rb(1, 0, 0, DB));
        @(posedge clk);
        #1;
        rst = 1'b1;
        R_request = 4'b1000; LSU_addr_bus = at(3, 16'h0010);
        @(negedge clk);
        chk("mid_bus_cleared", CBG_to_LSU_bus, 36'b0);
        chk("mid_busy", busy, 1);
        count_busy(n, ack_seen, bus_nz);
        chk("mid_busy_cycles", n, 256);
        chk("mid_ack_during_clear", ack_seen, 0);
        chk("mid_no_rsp_valid", bus_nz, 0);
        chk("first_serve_ack", req_ack, 4'b1000);
        @(posedge clk);
        #1;
        R_request = 4'b0100; LSU_addr_bus = at(2, 16'h0005);
        @(negedge clk);
        chk("post_clear_ack2", req_ack, 4'b0100);
        chk("post_clear_rd10", CBG_to_LSU_bus, rb(1, 0, 3, 0));
        @(posedge clk);
        #1;
        R_request = '0; LSU_addr_bus = '0;
        @(negedge clk);
        chk("post_clear_rd05", CBG_to_LSU_bus, rb(1, 0, 2, 0));
        chk("post_clear_busy", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
